// File: rtl/shannon_match_monitor_pkg.sv
// Shared types and default widths for the Shannon compare-stage match monitor.
package shannon_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned WIN_W_DEF = 8;
    localparam int unsigned RUN_W_DEF = 4;

    // Ceiling of the consecutive-match run counter at its default width.
    localparam logic [RUN_W_DEF-1:0] RUN_SAT = '1;

endpackage

// File: rtl/shannon_match_monitor_if.sv
// Control/status bundle between software-facing logic (master) and the monitor (slave).
// SHANNON_MON_OVF_EN adds the sticky ovf status signal.
interface shannon_match_monitor_if
    import shannon_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF,
    parameter int unsigned RUN_W = RUN_W_DEF
) ();

    logic             clr;
    logic             arm;
    logic             sample_vld;
    logic             match_in;
    logic [WIN_W-1:0] win_len;
    logic [RUN_W-1:0] run_thresh;
    logic             irq_ack;

    logic             busy;
    logic             win_done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [RUN_W-1:0] run_len;
    logic             irq;
`ifdef SHANNON_MON_OVF_EN
    logic             ovf;
`endif

    modport master (
        output clr, arm, sample_vld, match_in, win_len, run_thresh, irq_ack,
        input  busy, win_done, sample_cnt, match_cnt, run_len, irq
`ifdef SHANNON_MON_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  clr, arm, sample_vld, match_in, win_len, run_thresh, irq_ack,
        output busy, win_done, sample_cnt, match_cnt, run_len, irq
`ifdef SHANNON_MON_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/shannon_match_monitor_sat_cnt.sv
// Up-counter with synchronous clear (priority over enable) and saturate-or-wrap select.
// o_nxt exposes the value the counter takes at the next clock edge.
module shannon_sat_cnt #(
    parameter int unsigned W   = 8,
    parameter bit          SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_nxt
);

    logic [W-1:0] r_q;
    logic         w_full;

    assign w_full = (r_q == '1);

    always_comb begin
        o_nxt = r_q;
        if (i_clr)
            o_nxt = '0;
        else if (i_en && !(SAT && w_full))
            o_nxt = r_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else
            r_q <= o_nxt;
    end

    assign o_q = r_q;

endmodule

// File: rtl/shannon_match_monitor.sv
// Windowed match statistics and run-length interrupt for the Shannon compare stage.
// Optional: SHANNON_MON_OVF_EN saturates sample/match counters and adds sticky ovf.
module shannon_match_monitor
    import shannon_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF,
    parameter int unsigned RUN_W = RUN_W_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    shannon_match_monitor_if.slave bus
);

    localparam int unsigned CMP_W = (CNT_W > WIN_W) ? CNT_W : WIN_W;
`ifdef SHANNON_MON_OVF_EN
    localparam bit CNT_SAT = 1'b1;
`else
    localparam bit CNT_SAT = 1'b0;
`endif

    state_t           r_state;
    logic             r_busy;
    logic             r_win_done;
    logic             r_irq;

    logic             w_zero;
    logic             w_take;
    logic             w_match;
    logic             w_miss;
    logic             w_close;
    logic             w_irq_set;
    logic [CNT_W-1:0] w_sample_cnt;
    logic [CNT_W-1:0] w_sample_nxt;
    logic [CNT_W-1:0] w_match_cnt;
    logic [CNT_W-1:0] w_match_nxt;
    logic [RUN_W-1:0] w_run_len;
    logic [RUN_W-1:0] w_run_nxt;

    // arm in any state zeroes the counters and drops the sample of that cycle.
    assign w_zero  = bus.clr || bus.arm;
    assign w_take  = (r_state == ST_COUNT) && bus.sample_vld && !w_zero;
    assign w_match = w_take && bus.match_in;
    assign w_miss  = w_take && !bus.match_in;

    // win_len is compared live against the post-update count.
    assign w_close = w_take && (bus.win_len != '0)
                     && (CMP_W'(w_sample_nxt) == CMP_W'(bus.win_len));

    // Current-value guard keeps a saturated run sitting at the threshold from re-firing.
    assign w_irq_set = w_match && (bus.run_thresh != '0)
                       && (w_run_nxt == bus.run_thresh) && (w_run_len != bus.run_thresh);

    shannon_sat_cnt #(.W(CNT_W), .SAT(CNT_SAT)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_zero),
        .i_en  (w_take),
        .o_q   (w_sample_cnt),
        .o_nxt (w_sample_nxt)
    );

    shannon_sat_cnt #(.W(CNT_W), .SAT(CNT_SAT)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_zero),
        .i_en  (w_match),
        .o_q   (w_match_cnt),
        .o_nxt (w_match_nxt)
    );

    shannon_sat_cnt #(.W(RUN_W), .SAT(1'b1)) u_run_len (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_zero || w_miss),
        .i_en  (w_match),
        .o_q   (w_run_len),
        .o_nxt (w_run_nxt)
    );

`ifdef SHANNON_MON_OVF_EN
    logic r_ovf;
    logic w_ovf_hit;

    // A counted increment that leaves the counter unchanged is a saturation attempt.
    assign w_ovf_hit = (w_take && (w_sample_nxt == w_sample_cnt))
                       || (w_match && (w_match_nxt == w_match_cnt));
    assign bus.ovf   = r_ovf;
`else
    logic w_unused_nxt;
    assign w_unused_nxt = ^{w_sample_nxt, w_match_nxt};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_win_done <= 1'b0;
            r_irq      <= 1'b0;
`ifdef SHANNON_MON_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else if (bus.clr) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_win_done <= 1'b0;
            r_irq      <= 1'b0;
`ifdef SHANNON_MON_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.arm) begin
                        r_state    <= ST_COUNT;
                        r_busy     <= 1'b1;
                        r_win_done <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!bus.arm && w_close) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_win_done <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_win_done <= 1'b0;
                end
            endcase

            if (w_irq_set)
                r_irq <= 1'b1;
            else if (bus.irq_ack)
                r_irq <= 1'b0;
`ifdef SHANNON_MON_OVF_EN
            if (bus.arm)
                r_ovf <= 1'b0;
            else if (w_ovf_hit)
                r_ovf <= 1'b1;
`endif
        end
    end

    assign bus.busy       = r_busy;
    assign bus.win_done   = r_win_done;
    assign bus.sample_cnt = w_sample_cnt;
    assign bus.match_cnt  = w_match_cnt;
    assign bus.run_len    = w_run_len;
    assign bus.irq        = r_irq;

endmodule

// File: tb/tb_shannon_match_monitor.sv
// Bench for shannon_match_monitor: per-cycle model comparison plus hand-computed checkpoints.
module tb_shannon_match_monitor;
    import shannon_mon_pkg::*;

    localparam int unsigned CW   = 16;
    localparam int unsigned WW   = 8;
    localparam int unsigned RW   = 4;
    localparam int unsigned CW_B = 4;
`ifdef SHANNON_MON_OVF_EN
    localparam bit OVF_MODE = 1'b1;
`else
    localparam bit OVF_MODE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shannon_match_monitor_if #(.CNT_W(CW),   .WIN_W(WW), .RUN_W(RW)) bus_a ();
    shannon_match_monitor_if #(.CNT_W(CW_B), .WIN_W(WW), .RUN_W(RW)) bus_b ();

    shannon_match_monitor #(.CNT_W(CW), .WIN_W(WW), .RUN_W(RW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    shannon_match_monitor #(.CNT_W(CW_B), .WIN_W(WW), .RUN_W(RW)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of DUT A: window active flag, plain counters, run and irq rules.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_irq    = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_fired  = 1'b0;
    logic [15:0] m_samp   = '0;
    logic [15:0] m_match  = '0;
    int          m_run    = 0;

    task automatic model_clear();
        m_active = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_ovf = 1'b0; m_fired = 1'b0;
        m_samp = '0; m_match = '0; m_run = 0;
    endtask

    task automatic model_step();
        bit hit;
        hit = 1'b0;
        if (!rst_n || bus_a.clr) begin
            model_clear();
        end else begin
            if (bus_a.arm) begin
                m_samp = '0; m_match = '0; m_run = 0;
                m_active = 1'b1; m_done = 1'b0; m_ovf = 1'b0; m_fired = 1'b0;
            end else if (m_active && bus_a.sample_vld) begin
                if (OVF_MODE && m_samp == 16'hFFFF) m_ovf = 1'b1;
                else m_samp = m_samp + 16'd1;
                if (bus_a.match_in) begin
                    if (OVF_MODE && m_match == 16'hFFFF) m_ovf = 1'b1;
                    else m_match = m_match + 16'd1;
                    if (m_run < int'(RUN_SAT)) m_run = m_run + 1;
                    if (bus_a.run_thresh != 0 && m_run == int'(bus_a.run_thresh) && !m_fired) begin
                        hit = 1'b1;
                        m_fired = 1'b1;
                    end
                end else begin
                    m_run = 0;
                    m_fired = 1'b0;
                end
                if (bus_a.win_len != 0 && m_samp == 16'(bus_a.win_len)) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (hit) m_irq = 1'b1;
            else if (bus_a.irq_ack) m_irq = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("busy",       bus_a.busy,       m_active);
            chk("win_done",   bus_a.win_done,   m_done);
            chk("sample_cnt", bus_a.sample_cnt, m_samp);
            chk("match_cnt",  bus_a.match_cnt,  m_match);
            chk("run_len",    bus_a.run_len,    m_run);
            chk("irq",        bus_a.irq,        m_irq);
`ifdef SHANNON_MON_OVF_EN
            chk("ovf",        bus_a.ovf,        m_ovf);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp_a(input bit m);
        bus_a.sample_vld = 1'b1;
        bus_a.match_in   = m;
        tick();
        bus_a.sample_vld = 1'b0;
        bus_a.match_in   = 1'b0;
    endtask

    task automatic arm_a();
        bus_a.arm = 1'b1;
        tick();
        bus_a.arm = 1'b0;
    endtask

    bit pat_win [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit pat_rst [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        bus_a.clr = 0; bus_a.arm = 0; bus_a.sample_vld = 0; bus_a.match_in = 0;
        bus_a.win_len = '0; bus_a.run_thresh = '0; bus_a.irq_ack = 0;
        bus_b.clr = 0; bus_b.arm = 0; bus_b.sample_vld = 0; bus_b.match_in = 0;
        bus_b.win_len = '0; bus_b.run_thresh = '0; bus_b.irq_ack = 0;

        #12;
        chk("rst_busy",   bus_a.busy,       0);
        chk("rst_done",   bus_a.win_done,   0);
        chk("rst_sample", bus_a.sample_cnt, 0);
        chk("rst_irq",    bus_a.irq,        0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

        // IDLE ignores samples
        samp_a(1'b1);
        chk("idle_sample", bus_a.sample_cnt, 0);

        // Window of 8 with pattern 1,0,1,1,0,1,1,1
        bus_a.win_len = 8'd8; bus_a.run_thresh = 4'd0;
        arm_a();
        for (int i = 0; i < 8; i++) samp_a(pat_win[i]);
        chk("win_done",   bus_a.win_done,   1);
        chk("win_busy",   bus_a.busy,       0);
        chk("win_sample", bus_a.sample_cnt, 8);
        chk("win_match",  bus_a.match_cnt,  6);
        chk("win_run",    bus_a.run_len,    3);
        chk("win_irq",    bus_a.irq,        0);
        samp_a(1'b1);
        chk("done_frozen", bus_a.sample_cnt, 8);

        // Run interrupt from DONE via arm
        bus_a.win_len = 8'd0; bus_a.run_thresh = 4'd3;
        arm_a();
        chk("rearm_busy", bus_a.busy, 1);
        samp_a(1'b1); samp_a(1'b1);
        chk("irq_before", bus_a.irq, 0);
        samp_a(1'b1);
        chk("irq_rise", bus_a.irq, 1);
        bus_a.irq_ack = 1'b1;
        samp_a(1'b1);
        bus_a.irq_ack = 1'b0;
        for (int i = 0; i < 4; i++) samp_a(1'b1);
        chk("irq_no_retrig", bus_a.irq,     0);
        chk("run_8",         bus_a.run_len, 8);
        samp_a(1'b0);
        samp_a(1'b1); samp_a(1'b1);
        bus_a.irq_ack = 1'b1;
        samp_a(1'b1);
        bus_a.irq_ack = 1'b0;
        chk("irq_set_wins", bus_a.irq, 1);
        for (int i = 0; i < 14; i++) samp_a(1'b1);
        chk("run_sat",     bus_a.run_len,    15);
        chk("run_samples", bus_a.sample_cnt, 26);
        chk("run_matches", bus_a.match_cnt,  25);
        bus_a.irq_ack = 1'b1;
        tick();
        bus_a.irq_ack = 1'b0;
        chk("irq_ack", bus_a.irq, 0);

        // Restart mid-window with a concurrent sample, then clr+arm
        bus_a.win_len = 8'd20; bus_a.run_thresh = 4'd0;
        arm_a();
        for (int i = 0; i < 5; i++) samp_a(pat_rst[i]);
        chk("pre_restart", bus_a.sample_cnt, 5);
        bus_a.arm = 1'b1; bus_a.sample_vld = 1'b1; bus_a.match_in = 1'b1;
        tick();
        bus_a.arm = 1'b0; bus_a.sample_vld = 1'b0; bus_a.match_in = 1'b0;
        chk("restart_sample", bus_a.sample_cnt, 0);
        chk("restart_match",  bus_a.match_cnt,  0);
        chk("restart_run",    bus_a.run_len,    0);
        chk("restart_busy",   bus_a.busy,       1);
        samp_a(1'b1);
        bus_a.clr = 1'b1; bus_a.arm = 1'b1;
        tick();
        bus_a.clr = 1'b0; bus_a.arm = 1'b0;
        chk("clr_busy",   bus_a.busy,       0);
        chk("clr_done",   bus_a.win_done,   0);
        chk("clr_sample", bus_a.sample_cnt, 0);

        // win_len lowered below the count mid-window, then raised again
        bus_a.win_len = 8'd10;
        arm_a();
        for (int i = 0; i < 4; i++) samp_a(1'b1);
        bus_a.win_len = 8'd2;
        for (int i = 0; i < 3; i++) samp_a(1'b1);
        chk("live_busy",   bus_a.busy,       1);
        chk("live_sample", bus_a.sample_cnt, 7);
        bus_a.win_len = 8'd9;
        samp_a(1'b0); samp_a(1'b1);
        chk("live_done",   bus_a.win_done,   1);
        chk("live_final",  bus_a.sample_cnt, 9);

        // Asynchronous reset mid-window with irq set
        bus_a.win_len = 8'd0; bus_a.run_thresh = 4'd2;
        arm_a();
        for (int i = 0; i < 3; i++) samp_a(1'b1);
        chk("pre_rst_sample", bus_a.sample_cnt, 3);
        chk("pre_rst_irq",    bus_a.irq,        1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy",   bus_a.busy,       0);
        chk("arst_sample", bus_a.sample_cnt, 0);
        chk("arst_match",  bus_a.match_cnt,  0);
        chk("arst_run",    bus_a.run_len,    0);
        chk("arst_irq",    bus_a.irq,        0);
        #1 rst_n = 1'b1;
        tick();

        // Free-running 4-bit counters, 17 matching samples
        bus_b.win_len = 8'd0; bus_b.run_thresh = 4'd0;
        bus_b.arm = 1'b1;
        tick();
        bus_b.arm = 1'b0;
        bus_b.sample_vld = 1'b1; bus_b.match_in = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus_b.sample_vld = 1'b0; bus_b.match_in = 1'b0;
`ifdef SHANNON_MON_OVF_EN
        chk("small_match_sat",  bus_b.match_cnt,  15);
        chk("small_sample_sat", bus_b.sample_cnt, 15);
        chk("small_ovf",        bus_b.ovf,        1);
`else
        chk("small_match_wrap",  bus_b.match_cnt,  1);
        chk("small_sample_wrap", bus_b.sample_cnt, 1);
`endif
        chk("small_busy", bus_b.busy, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
